// File: rtl/instr_pkg.sv
// Definitions shared by the instruction encoder and decoder: opcodes, word
// field positions, control-bit indices and the encoder state encoding.
package instr_pkg;

  localparam logic [3:0] OPC_REGSRC = 4'b0010;
  localparam logic [3:0] OPC_BRANCH = 4'b0011;

  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 28;
  localparam int CC_MSB   = 27;
  localparam int CC_LSB   = 24;
  localparam int SRC_MSB  = 23;
  localparam int SRC_LSB  = 12;
  localparam int DEST_MSB = 11;
  localparam int DEST_LSB = 0;

  localparam int CC_SRC_REG  = 3;
  localparam int CC_DEST_REG = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } enc_state_t;

  // Register-source opcodes always read a register; branches never write one.
  function automatic logic [3:0] normalise_cc(input logic [3:0] opcode,
                                              input logic [3:0] cc);
    logic [3:0] res;
    res = cc;
    if (opcode == OPC_REGSRC) res[CC_SRC_REG] = 1'b1;
    if (opcode == OPC_BRANCH) res[CC_DEST_REG] = 1'b0;
    return res;
  endfunction

  function automatic logic [31:0] pack_word(input logic [3:0]  opcode,
                                            input logic [3:0]  cc,
                                            input logic [11:0] src,
                                            input logic [11:0] dest);
    logic [31:0] w;
    w = '0;
    w[OPC_MSB:OPC_LSB]   = opcode;
    w[CC_MSB:CC_LSB]     = cc;
    w[SRC_MSB:SRC_LSB]   = src;
    w[DEST_MSB:DEST_LSB] = dest;
    return w;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Small synchronous show-ahead FIFO; dout presents the oldest entry whenever
// the FIFO is non-empty so a pop and its data land on the same edge.
module instr_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]          wr_ptr_reg;
  logic [PTR_W:0]          rd_ptr_reg;
  logic [DATA_WIDTH-1:0]   mem_reg [DEPTH];
  logic                    do_push;
  logic                    do_pop;

  // The extra pointer bit distinguishes full (lap differs) from empty.
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                 (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_reg[rd_ptr_reg[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg[PTR_W-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + (PTR_W+1)'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (PTR_W+1)'(1);
    end
  end

endmodule

// File: rtl/instruction_encoder.sv
// Packs and normalises instruction field tuples, buffers them, and writes the
// encoded words to consecutive instruction-memory addresses from a base.
module instruction_encoder
  import instr_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_adrs,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_opcode,
  input  logic [3:0]               in_cc,
  input  logic [ADDRESS_WIDTH-1:0] in_src,
  input  logic [ADDRESS_WIDTH-1:0] in_dest,
  input  logic                     in_last,
  output logic                     mem_w_en,
  output logic [ADDRESS_WIDTH-1:0] mem_w_adrs,
  output logic [DATA_WIDTH-1:0]    mem_w_data,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH:0]   count,
  output logic                     norm_flag,
  output logic                     wrap_flag
);

  localparam logic [ADDRESS_WIDTH:0] COUNT_MAX = {1'b1, {ADDRESS_WIDTH{1'b0}}};

  enc_state_t               state_reg;
  logic [ADDRESS_WIDTH-1:0] adrs_reg;
  logic                     mem_w_en_reg;
  logic [ADDRESS_WIDTH-1:0] mem_w_adrs_reg;
  logic [DATA_WIDTH-1:0]    mem_w_data_reg;
  logic                     busy_reg;
  logic                     done_reg;
  logic [ADDRESS_WIDTH:0]   count_reg;
  logic                     norm_flag_reg;
  logic                     wrap_flag_reg;

  logic [3:0]               norm_cc;
  logic [DATA_WIDTH-1:0]    push_word;
  logic [DATA_WIDTH-1:0]    fifo_dout;
  logic                     fifo_push;
  logic                     fifo_pop;
  logic                     fifo_flush;
  logic                     fifo_full;
  logic                     fifo_empty;

  assign in_ready   = (state_reg == RUN) && !fifo_full;
  assign fifo_push  = in_valid && in_ready;
  assign fifo_pop   = ((state_reg == RUN) || (state_reg == DRAIN)) && !fifo_empty;
  assign fifo_flush = (state_reg == IDLE) && start;

  always_comb begin
    norm_cc   = normalise_cc(in_opcode, in_cc);
    push_word = pack_word(in_opcode, norm_cc, in_src, in_dest);
  end

  instr_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (fifo_flush),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (push_word),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      adrs_reg       <= '0;
      mem_w_en_reg   <= 1'b0;
      mem_w_adrs_reg <= '0;
      mem_w_data_reg <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      count_reg      <= '0;
      norm_flag_reg  <= 1'b0;
      wrap_flag_reg  <= 1'b0;
    end else begin
      done_reg     <= 1'b0;
      mem_w_en_reg <= fifo_pop;

      if (fifo_pop) begin
        mem_w_adrs_reg <= adrs_reg;
        mem_w_data_reg <= fifo_dout;
        adrs_reg       <= adrs_reg + ADDRESS_WIDTH'(1);
        if (adrs_reg == '1) wrap_flag_reg <= 1'b1;
        if (count_reg != COUNT_MAX) count_reg <= count_reg + (ADDRESS_WIDTH+1)'(1);
      end

      if (fifo_push && (norm_cc != in_cc)) norm_flag_reg <= 1'b1;

      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg     <= RUN;
            busy_reg      <= 1'b1;
            adrs_reg      <= base_adrs;
            count_reg     <= '0;
            norm_flag_reg <= 1'b0;
            wrap_flag_reg <= 1'b0;
          end
        end
        RUN: begin
          if (fifo_push && in_last) state_reg <= DRAIN;
        end
        DRAIN: begin
          // An empty FIFO means no pop this cycle, so the final write is already out.
          if (fifo_empty) begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_w_en   = mem_w_en_reg;
  assign mem_w_adrs = mem_w_adrs_reg;
  assign mem_w_data = mem_w_data_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign count      = count_reg;
  assign norm_flag  = norm_flag_reg;
  assign wrap_flag  = wrap_flag_reg;

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder: hand-computed words, addresses,
// latencies and flags checked with immediate assertions.
module tb_instruction_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [11:0] base_adrs = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_opcode = '0;
  logic [3:0]  in_cc = '0;
  logic [11:0] in_src = '0;
  logic [11:0] in_dest = '0;
  logic        in_last = 1'b0;
  logic        mem_w_en;
  logic [11:0] mem_w_adrs;
  logic [31:0] mem_w_data;
  logic        busy;
  logic        done;
  logic [12:0] count;
  logic        norm_flag;
  logic        wrap_flag;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stall_cycles = 0;
  bit quiet = 1'b0;

  logic [11:0] wq_adrs[$];
  logic [31:0] wq_data[$];
  int          wq_cyc[$];

  instruction_encoder dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_adrs  (base_adrs),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_cc      (in_cc),
    .in_src     (in_src),
    .in_dest    (in_dest),
    .in_last    (in_last),
    .mem_w_en   (mem_w_en),
    .mem_w_adrs (mem_w_adrs),
    .mem_w_data (mem_w_data),
    .busy       (busy),
    .done       (done),
    .count      (count),
    .norm_flag  (norm_flag),
    .wrap_flag  (wrap_flag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_w_en === 1'b1) begin
      wq_adrs.push_back(mem_w_adrs);
      wq_data.push_back(mem_w_data);
      wq_cyc.push_back(cyc);
      if (!quiet) $display("write adrs=0x%03h data=0x%08h cycle=%0d", mem_w_adrs, mem_w_data, cyc);
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: observed no finish, expected finish before 5ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wq_adrs.delete();
    wq_data.delete();
    wq_cyc.delete();
  endtask

  task automatic do_start(input logic [11:0] base);
    start = 1'b1;
    base_adrs = base;
    tick();
    start = 1'b0;
    base_adrs = 12'hABC;
  endtask

  task automatic send(input logic [3:0] op, input logic [3:0] cc,
                      input logic [11:0] src, input logic [11:0] dest, input logic last);
    int waits = 0;
    in_valid = 1'b1;
    in_opcode = op;
    in_cc = cc;
    in_src = src;
    in_dest = dest;
    in_last = last;
    while (in_ready !== 1'b1 && waits < 20) begin
      tick();
      waits++;
    end
    stall_cycles += waits;
    if (in_ready !== 1'b1) check("accept_timeout", 64'(in_ready), 64'(1));
    tick();
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_done"}, 64'(done), 64'(1));
    tick();
    check({tag, "_idle"}, 64'(busy), 64'(0));
  endtask

  task automatic expect_write(input string tag, input int k,
                              input logic [11:0] a, input logic [31:0] d);
    if (k < wq_adrs.size()) begin
      check({tag, "_adrs"}, 64'(wq_adrs[k]), 64'(a));
      check({tag, "_data"}, 64'(wq_data[k]), 64'(d));
    end else begin
      check({tag, "_nwrites"}, 64'(wq_adrs.size()), 64'(k + 1));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  64'(in_ready),   64'(0));
    check({tag, "_mem_w_en"},  64'(mem_w_en),   64'(0));
    check({tag, "_adrs"},      64'(mem_w_adrs), 64'(0));
    check({tag, "_data"},      64'(mem_w_data), 64'(0));
    check({tag, "_busy"},      64'(busy),       64'(0));
    check({tag, "_done"},      64'(done),       64'(0));
    check({tag, "_count"},     64'(count),      64'(0));
    check({tag, "_norm"},      64'(norm_flag),  64'(0));
    check({tag, "_wrap"},      64'(wrap_flag),  64'(0));
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check_reset_outputs("rst");
    rst = 1'b0;
    tick();
    check("rst_idle_ready", 64'(in_ready), 64'(0));

    // Single tuple, exact latency
    clear_log();
    do_start(12'h010);
    check("t1_busy", 64'(busy), 64'(1));
    check("t1_ready", 64'(in_ready), 64'(1));
    send(4'b0001, 4'b1100, 12'h005, 12'h020, 1'b1);
    check("t1_no_write_yet", 64'(mem_w_en), 64'(0));
    tick();
    check("t1_w_en", 64'(mem_w_en), 64'(1));
    check("t1_w_adrs", 64'(mem_w_adrs), 64'(12'h010));
    check("t1_w_data", 64'(mem_w_data), 64'(32'h1C005020));
    check("t1_done_early", 64'(done), 64'(0));
    tick();
    check("t1_done", 64'(done), 64'(1));
    check("t1_w_en_off", 64'(mem_w_en), 64'(0));
    check("t1_busy_done", 64'(busy), 64'(1));
    tick();
    check("t1_done_pulse", 64'(done), 64'(0));
    check("t1_busy_off", 64'(busy), 64'(0));
    check("t1_count", 64'(count), 64'(1));
    check("t1_norm", 64'(norm_flag), 64'(0));
    check("t1_wrap", 64'(wrap_flag), 64'(0));
    check("t1_nwrites", 64'(wq_adrs.size()), 64'(1));

    // Normalisation that changes bits
    clear_log();
    do_start(12'h200);
    send(4'b0010, 4'b0000, 12'h123, 12'h456, 1'b0);
    send(4'b0011, 4'b0100, 12'h007, 12'h008, 1'b1);
    wait_done("t2");
    expect_write("t2_w0", 0, 12'h200, 32'h28123456);
    expect_write("t2_w1", 1, 12'h201, 32'h30007008);
    check("t2_norm", 64'(norm_flag), 64'(1));
    check("t2_count", 64'(count), 64'(2));

    // Rule opcodes whose bits already comply: no normalisation, flag cleared by start
    clear_log();
    do_start(12'h600);
    send(4'b0010, 4'b1001, 12'h001, 12'h002, 1'b0);
    send(4'b0011, 4'b1010, 12'h003, 12'h004, 1'b1);
    wait_done("t2b");
    expect_write("t2b_w0", 0, 12'h600, 32'h29001002);
    expect_write("t2b_w1", 1, 12'h601, 32'h3A003004);
    check("t2b_norm", 64'(norm_flag), 64'(0));

    // Streaming: 8 back-to-back tuples
    clear_log();
    stall_cycles = 0;
    do_start(12'h500);
    for (int i = 0; i < 8; i++)
      send(4'h1, 4'(i), 12'(12'h100 + i), 12'(12'h200 + i), (i == 7));
    wait_done("t3");
    check("t3_stalls", 64'(stall_cycles), 64'(0));
    check("t3_nwrites", 64'(wq_adrs.size()), 64'(8));
    for (int i = 0; i < 8; i++)
      expect_write("t3_w", i, 12'(12'h500 + i),
                   {4'h1, 4'(i), 12'(12'h100 + i), 12'(12'h200 + i)});
    if (wq_cyc.size() == 8)
      for (int i = 1; i < 8; i++)
        check("t3_b2b", 64'(wq_cyc[i] - wq_cyc[i-1]), 64'(1));
    check("t3_count", 64'(count), 64'(8));

    // Address wrap
    clear_log();
    do_start(12'hFFE);
    send(4'h4, 4'h0, 12'h001, 12'h001, 1'b0);
    send(4'h4, 4'h0, 12'h002, 12'h002, 1'b0);
    send(4'h4, 4'h0, 12'h003, 12'h003, 1'b1);
    wait_done("t4");
    expect_write("t4_w0", 0, 12'hFFE, 32'h40001001);
    expect_write("t4_w1", 1, 12'hFFF, 32'h40002002);
    expect_write("t4_w2", 2, 12'h000, 32'h40003003);
    check("t4_wrap", 64'(wrap_flag), 64'(1));
    check("t4_count", 64'(count), 64'(3));

    // Count saturation: 4097 writes
    clear_log();
    quiet = 1'b1;
    do_start(12'h000);
    for (int i = 0; i < 4097; i++)
      send(4'h1, 4'h0, 12'(i), 12'(i), (i == 4096));
    wait_done("t5");
    quiet = 1'b0;
    check("t5_nwrites", 64'(wq_adrs.size()), 64'(4097));
    check("t5_count_sat", 64'(count), 64'(13'h1000));
    check("t5_wrap", 64'(wrap_flag), 64'(1));
    $display("saturation load: %0d writes, count=0x%0h", wq_adrs.size(), count);

    // Reset mid-load
    do_start(12'h300);
    send(4'h1, 4'h0, 12'h111, 12'h222, 1'b0);
    clear_log();
    in_valid = 1'b1;
    in_opcode = 4'h1;
    in_src = 12'h333;
    in_dest = 12'h444;
    rst = 1'b1;
    tick();
    in_valid = 1'b0;
    check_reset_outputs("t6_rst");
    rst = 1'b0;
    tick();
    check("t6_no_write", 64'(mem_w_en), 64'(0));
    check("t6_idle", 64'(busy), 64'(0));
    do_start(12'h100);
    send(4'h5, 4'h0, 12'h0AA, 12'h0BB, 1'b0);
    send(4'h6, 4'h0, 12'h0CC, 12'h0DD, 1'b1);
    wait_done("t6");
    check("t6_nwrites", 64'(wq_adrs.size()), 64'(2));
    expect_write("t6_w0", 0, 12'h100, 32'h500AA0BB);
    expect_write("t6_w1", 1, 12'h101, 32'h600CC0DD);
    check("t6_count", 64'(count), 64'(2));

    // start during RUN is ignored
    clear_log();
    do_start(12'h400);
    send(4'h7, 4'h0, 12'h001, 12'h002, 1'b0);
    start = 1'b1;
    base_adrs = 12'h700;
    tick();
    start = 1'b0;
    check("t7_still_run", 64'(in_ready), 64'(1));
    send(4'h8, 4'h0, 12'h003, 12'h004, 1'b1);
    wait_done("t7");
    check("t7_nwrites", 64'(wq_adrs.size()), 64'(2));
    expect_write("t7_w0", 0, 12'h400, 32'h70001002);
    expect_write("t7_w1", 1, 12'h401, 32'h80003004);
    check("t7_count", 64'(count), 64'(2));
    check("t7_wrap", 64'(wrap_flag), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_encoder.md
# instruction_encoder

Packs instruction fields into 32-bit instruction words and writes them sequentially into instruction memory. It is the write-side counterpart of the instruction decoder. A host or test sequencer streams field tuples over a valid/ready handshake. The block normalises each tuple so the decoder's interpretation is unambiguous, buffers the words in a small FIFO, and drains them to consecutive memory addresses from a programmable base.

## Interface
- DATA_WIDTH, 32, instruction word width
- ADDRESS_WIDTH, 12, memory address and operand field width
- FIFO_DEPTH, 4, encoded-word buffer entries (power of two, ≥2)

- clk  in  1  clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a program load (sampled only in IDLE)
- base_adrs  in  ADDRESS_WIDTH  first write address, captured on start
- in_valid  in  1  field tuple valid
- in_ready  out  1  block can accept a tuple
- in_opcode  in  4  opcode
- in_cc  in  4  condition/control bits: [3] src-is-register, [2] dest-is-register
- in_src  in  ADDRESS_WIDTH  source immediate or register address
- in_dest  in  ADDRESS_WIDTH  destination/branch address
- in_last  in  1  tuple is the final instruction of the program
- mem_w_en  out  1  instruction memory write strobe
- mem_w_adrs  out  ADDRESS_WIDTH  write address
- mem_w_data  out  DATA_WIDTH  encoded word
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse when the last word has been written
- count  out  ADDRESS_WIDTH+1  words written in the current load
- norm_flag  out  1  sticky: at least one tuple was normalised
- wrap_flag  out  1  sticky: write address wrapped past all-ones

## Operation
- Encoding: word = {opcode, cc, src, dest} in bits [31:28], [27:24], [23:12], [11:0].
- Normalisation, applied at accept:
  - If opcode = 4'b0010, force cc[3]=1.
  - If opcode = 4'b0011 (branch), force cc[2]=0.
  - If either rule changes a bit, set norm_flag.
- FSM states:
  - IDLE: start goes to RUN. On that edge, capture base_adrs, clear count, norm_flag and wrap_flag, and flush the FIFO.
  - RUN: accept tuples. Accepting a tuple with in_last=1 goes to DRAIN.
  - DRAIN: no accepts. Go to DONE when the FIFO is empty and no write is issuing.
  - DONE: done=1 for this single cycle, then go to IDLE.
- start is ignored outside IDLE. The last tuple of a load must carry in_last; a load has no timeout.
- Drain: in RUN and DRAIN, whenever the FIFO is non-empty, pop one word per cycle.
  - Each pop issues a registered write at the current address.
  - The address then increments modulo 2^ADDRESS_WIDTH, and count increments.
  - An increment from all-ones to 0 sets wrap_flag. Writes continue after a wrap.
- count saturates at 2^ADDRESS_WIDTH.
- Flags and count hold their values in IDLE until the next start.

## Timing
- in_ready = (state==RUN) && !fifo_full. It is combinational from registered state.
- A tuple is accepted on a cycle where in_valid && in_ready.
- Latency: a word accepted at edge N appears with mem_w_en=1 at edge N+1 if the FIFO was empty. Back-to-back accepts give back-to-back writes at one word per cycle.
- Pushing and popping in the same cycle is allowed. Occupancy is unchanged.
- When full, in_ready=0 until a pop occurs. A push that would overflow can never happen.
- done asserts the cycle after the final write's mem_w_en cycle. busy deasserts together with the DONE→IDLE transition.
- Reset values: in_ready 0, mem_w_en 0, mem_w_adrs 0, mem_w_data 0, busy 0, done 0, count 0, norm_flag 0, wrap_flag 0, FIFO empty, state IDLE.
- Reset mid-load: on the next edge all outputs take their reset values and FIFO contents are discarded. No write is issued in the cycle following reset.

## Structure
- Package instr_pkg:
  - OPC_REGSRC = 4'b0010, OPC_BRANCH = 4'b0011
  - Field bit positions and CC_SRC_REG=3, CC_DEST_REG=2
  - Encoder state enum {IDLE, RUN, DRAIN, DONE}
  - Also shared by the decoder.
- Sub-module instr_fifo: parameterised synchronous FIFO.
  - Ports: push, pop, din, dout, full, empty, flush.
  - Pointers carry one extra bit for full/empty detection.
- Encoding, normalisation, FSM, address counter and flags live in instruction_encoder.

## Test plan
- Single tuple, base 0x010: start, then opcode 0001, cc 1100, src 0x005, dest 0x020, last → one write of 0x1C005020 at 0x010, done one cycle later, count=1, norm_flag=0.
- Normalisation: opcode 0010 cc 0000 → word 0x28…; opcode 0011 cc 0100 → cc written 0000. norm_flag=1 after either case.
- Backpressure: hold in_valid for 8 tuples while mem writes proceed. Expect in_ready never asserted while the FIFO is full, all 8 words written in order at consecutive addresses, and no loss or duplication.
- Wrap: base 0xFFE, 3 tuples → writes at 0xFFE, 0xFFF, 0x000; wrap_flag=1; count=3.
- Reset on the second of four tuples → the next cycle shows all outputs at reset values and mem_w_en=0. A new start from base 0x100 then writes only the new program.
- start asserted during RUN → ignored; base address and count are unchanged.
